// File: rtl/opb_sw_reg_pkg.sv
// Shared definitions for the OPB software registers (simulink2ppc and ppc2simulink).
// Covers register offsets, status-word field positions and the slave handshake states.
package opb_sw_reg_pkg;

  localparam logic [31:0] OFF_DATA   = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0004;

  localparam int unsigned STAT_NEW = 0;
  localparam int unsigned STAT_OVF = 1;
  localparam int unsigned CNT_LSB  = 16;
  localparam int unsigned CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } ack_state_e;

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave handshake: address-window hit, a single registered ack per select,
// and capture of the transfer attributes for use during the ack cycle.
module opb_slave_ack_fsm
  import opb_sw_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR = 32'h0000_00FF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_addr,
  input  logic        i_select,
  input  logic        i_rnw,
  input  logic [0:3]  i_be,
  input  logic [31:0] i_wdata,
  output logic        o_hit,
  output logic [31:0] o_offset,
  output logic        o_ack,
  output logic [31:0] o_offset_q,
  output logic        o_rnw_q,
  output logic [0:3]  o_be_q,
  output logic [31:0] o_wdata_q
);

  localparam logic [31:0] SPAN = C_HIGHADDR - C_BASEADDR;

  ack_state_e  r_state;
  ack_state_e  w_state_next;
  logic        r_ack;
  logic [31:0] w_off;
  logic        w_in_range;
  logic [31:0] r_offset_q;
  logic        r_rnw_q;
  logic [0:3]  r_be_q;
  logic [31:0] r_wdata_q;

  // Addresses below the base wrap to large offsets, so one compare bounds both ends.
  assign w_off      = i_addr - C_BASEADDR;
  assign w_in_range = (w_off <= SPAN);
  assign o_offset   = {w_off[31:2], 2'b00};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_next = r_state;
    o_hit        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_select && w_in_range) begin
          o_hit        = 1'b1;
          w_state_next = ACK;
        end
      end
      ACK:     w_state_next = WAIT;
      WAIT:    if (!i_select) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments, so every register here sees pre-edge values.
    if (i_rst) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ack   <= o_hit;
    end
  end

  // NOTE: transfer attributes carry no reset; they are only consumed while r_ack is high.
  always_ff @(posedge i_clk) begin
    if (o_hit) begin
      r_offset_q <= o_offset;
      r_rnw_q    <= i_rnw;
      r_be_q     <= i_be;
      r_wdata_q  <= i_wdata;
    end
  end

  assign o_ack      = r_ack;
  assign o_offset_q = r_offset_q;
  assign o_rnw_q    = r_rnw_q;
  assign o_be_q     = r_be_q;
  assign o_wdata_q  = r_wdata_q;

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// Read-only OPB register publishing a fabric value to the PowerPC, with a
// NEW/OVF/CNT status word (NEW and OVF are write-1-to-clear).
module opb_register_simulink2ppc
  import opb_sw_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [31:0]             user_data_in,
  input  logic                    user_valid
);

  logic [31:0]      w_addr;
  logic [31:0]      w_wdata;
  logic             w_hit;
  logic [31:0]      w_offset;
  logic             w_ack;
  logic [31:0]      w_offset_q;
  logic             w_rnw_q;
  logic [0:3]       w_be_q;
  logic [31:0]      w_wdata_q;

  logic [31:0]      r_data;
  logic             r_new;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_sl_dbus;

  logic [31:0]      w_status;
  logic [31:0]      w_rd_word;
  logic             w_sts_wr;
  logic             w_clr_new;
  logic             w_clr_ovf;
  logic             w_new_next;
  logic             w_ovf_next;
  logic             w_unused_ok;

  // OPB bit 0 is the MSB, so a positional copy gives the [31:0] value directly.
  assign w_addr  = OPB_ABus;
  assign w_wdata = OPB_DBus;

  opb_slave_ack_fsm #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_ack_fsm (
    .i_clk      (OPB_Clk),
    .i_rst      (OPB_Rst),
    .i_addr     (w_addr),
    .i_select   (OPB_select),
    .i_rnw      (OPB_RNW),
    .i_be       (OPB_BE),
    .i_wdata    (w_wdata),
    .o_hit      (w_hit),
    .o_offset   (w_offset),
    .o_ack      (w_ack),
    .o_offset_q (w_offset_q),
    .o_rnw_q    (w_rnw_q),
    .o_be_q     (w_be_q),
    .o_wdata_q  (w_wdata_q)
  );

  always_comb begin
    w_status                     = '0;
    w_status[STAT_NEW]           = r_new;
    w_status[STAT_OVF]           = r_ovf;
    w_status[CNT_LSB +: CNT_W]   = r_cnt;
  end

  always_comb begin
    w_rd_word = '0;
    if (w_offset == OFF_DATA) begin
      w_rd_word = r_data;
    end else if (w_offset == OFF_STATUS) begin
      w_rd_word = w_status;
    end
  end

  // Clears act in the ack cycle; a capture in that same cycle wins over them.
  assign w_sts_wr   = w_ack && !w_rnw_q && (w_offset_q == OFF_STATUS) && w_be_q[3];
  assign w_clr_new  = (w_ack && w_rnw_q && (w_offset_q == OFF_DATA))
                   || (w_sts_wr && w_wdata_q[STAT_NEW]);
  assign w_clr_ovf  = w_sts_wr && w_wdata_q[STAT_OVF];
  assign w_new_next = user_valid ? 1'b1 : (w_clr_new ? 1'b0 : r_new);
  assign w_ovf_next = (user_valid && r_new && !w_clr_new) ? 1'b1
                    : (w_clr_ovf ? 1'b0 : r_ovf);

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      r_data    <= '0;
      r_new     <= 1'b0;
      r_ovf     <= 1'b0;
      r_cnt     <= '0;
      r_sl_dbus <= '0;
    end else begin
      r_sl_dbus <= (w_hit && OPB_RNW) ? w_rd_word : '0;
      r_new     <= w_new_next;
      r_ovf     <= w_ovf_next;
      if (user_valid) begin
        r_data <= user_data_in;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign Sl_DBus    = r_sl_dbus;
  assign Sl_xferAck = w_ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign w_unused_ok = &{1'b0, OPB_seqAddr, w_be_q[0:2], w_wdata_q[31:2]};

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Directed bench for opb_register_simulink2ppc: stimulus pushes expected acks into
// a queue, a negedge monitor pops and compares whenever Sl_xferAck is seen.
module tb_opb_register_simulink2ppc;

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic [31:0] user_data_in;
  logic        user_valid;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   ack_count = 0;
  int   tag       = 0;

  opb_register_simulink2ppc dut (
    .OPB_Clk      (OPB_Clk),
    .OPB_Rst      (OPB_Rst),
    .OPB_ABus     (OPB_ABus),
    .OPB_BE       (OPB_BE),
    .OPB_DBus     (OPB_DBus),
    .OPB_RNW      (OPB_RNW),
    .OPB_select   (OPB_select),
    .OPB_seqAddr  (OPB_seqAddr),
    .Sl_DBus      (Sl_DBus),
    .Sl_xferAck   (Sl_xferAck),
    .Sl_errAck    (Sl_errAck),
    .Sl_retry     (Sl_retry),
    .Sl_toutSup   (Sl_toutSup),
    .user_data_in (user_data_in),
    .user_valid   (user_valid)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every ack must match the oldest queued expectation; idle bus must be zero.
  initial begin
    exp_t e;
    forever begin
      @(negedge OPB_Clk);
      if (Sl_xferAck === 1'b1) begin
        ack_count++;
        if (sb.size() == 0) begin
          check("unexpected_ack", {31'b0, Sl_xferAck}, 32'h0);
        end else begin
          e = sb.pop_front();
          if (e.is_read) check($sformatf("read_data_%0d", e.tag), Sl_DBus, e.data);
        end
      end else begin
        check("dbus_zero_without_ack", Sl_DBus, 32'h0);
      end
      check("const_outputs_zero", {29'b0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'h0);
    end
  end

  // Entered on a negedge. Holds select for 'hold' cycles; optionally pulses user_valid in the ack cycle.
  task automatic xfer(input logic [31:0] addr, input bit rnw, input logic [3:0] be,
                      input logic [31:0] wdata, input logic [31:0] exp, input int hold,
                      input bit uv, input logic [31:0] uv_data, input bit exp_ack);
    int   start;
    int   last;
    exp_t e;
    start = ack_count;
    if (exp_ack) begin
      e.is_read = rnw;
      e.data    = exp;
      e.tag     = tag;
      sb.push_back(e);
    end
    tag++;
    OPB_ABus   = addr;
    OPB_RNW    = rnw;
    OPB_BE     = be;
    OPB_DBus   = rnw ? 32'h0 : wdata;
    OPB_select = 1'b1;
    last = ((hold < 2) ? 2 : hold) + 2;
    for (int c = 1; c <= last; c++) begin
      @(negedge OPB_Clk);
      if (c == 1) begin
        check($sformatf("ack_at_t1_%0d", tag - 1), {31'b0, Sl_xferAck}, {31'b0, exp_ack});
        if (uv) begin
          user_valid   = 1'b1;
          user_data_in = uv_data;
        end
      end
      if (c == 2) user_valid = 1'b0;
      if (c == hold) OPB_select = 1'b0;
    end
    #1 check($sformatf("ack_count_%0d", tag - 1), ack_count - start, {31'b0, exp_ack});
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    xfer(addr, 1'b1, 4'b1111, 32'h0, exp, 1, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    xfer(addr, 1'b0, be, data, 32'h0, 1, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic pulse(input logic [31:0] data);
    @(negedge OPB_Clk);
    user_valid   = 1'b1;
    user_data_in = data;
    @(negedge OPB_Clk);
    user_valid   = 1'b0;
  endtask

  initial begin
    int start;
    exp_t e;
    OPB_Rst      = 1'b1;
    OPB_ABus     = '0;
    OPB_BE       = '0;
    OPB_DBus     = '0;
    OPB_RNW      = 1'b0;
    OPB_select   = 1'b0;
    OPB_seqAddr  = 1'b0;
    user_data_in = '0;
    user_valid   = 1'b0;
    repeat (3) @(negedge OPB_Clk);
    check("reset_ack", {31'b0, Sl_xferAck}, 32'h0);
    check("reset_dbus", Sl_DBus, 32'h0);
    OPB_Rst = 1'b0;
    @(negedge OPB_Clk);

    rd(32'h0, 32'h0000_0000);
    rd(32'h4, 32'h0000_0000);

    pulse(32'hDEAD_BEEF);
    rd(32'h4, 32'h0001_0001);
    rd(32'h0, 32'hDEAD_BEEF);
    rd(32'h4, 32'h0001_0000);

    pulse(32'h1);
    pulse(32'h2);
    rd(32'h4, 32'h0003_0003);
    wr(32'h4, 4'b0001, 32'h0000_0002);
    rd(32'h4, 32'h0003_0001);
    wr(32'h4, 4'b1110, 32'h0000_0003);
    rd(32'h4, 32'h0003_0001);

    // Capture coincident with a DATA read ack: old data returned, NEW held, OVF untouched.
    xfer(32'h0, 1'b1, 4'b1111, 32'h0, 32'h0000_0002, 1, 1'b1, 32'h5, 1'b1);
    rd(32'h4, 32'h0004_0001);
    rd(32'h0, 32'h0000_0005);
    rd(32'h4, 32'h0004_0000);

    // Capture coincident with an OVF clear while NEW is set: overflow re-asserts.
    pulse(32'hA);
    pulse(32'hB);
    rd(32'h4, 32'h0006_0003);
    xfer(32'h4, 1'b0, 4'b0001, 32'h0000_0002, 32'h0, 1, 1'b1, 32'hC, 1'b1);
    rd(32'h4, 32'h0007_0003);
    wr(32'h4, 4'b0001, 32'h0000_0003);
    rd(32'h4, 32'h0007_0000);

    wr(32'h0, 4'b1111, 32'hFFFF_FFFF);
    rd(32'h0, 32'h0000_000C);
    rd(32'h4, 32'h0007_0000);
    rd(32'h8, 32'h0000_0000);
    wr(32'h8, 4'b1111, 32'hFFFF_FFFF);
    rd(32'hFC, 32'h0000_0000);
    rd(32'h4, 32'h0007_0000);

    xfer(32'h4, 1'b1, 4'b1111, 32'h0, 32'h0007_0000, 6, 1'b0, 32'h0, 1'b1);
    xfer(32'h100, 1'b1, 4'b1111, 32'h0, 32'h0, 3, 1'b0, 32'h0, 1'b0);
    xfer(32'h103, 1'b1, 4'b1111, 32'h0, 32'h0, 3, 1'b0, 32'h0, 1'b0);

    // Reset asserted during the ack cycle.
    start     = ack_count;
    e.is_read = 1'b1;
    e.data    = 32'h0007_0000;
    e.tag     = tag++;
    sb.push_back(e);
    OPB_ABus   = 32'h4;
    OPB_RNW    = 1'b1;
    OPB_BE     = 4'b1111;
    OPB_select = 1'b1;
    @(negedge OPB_Clk);
    check("rst_xfer_ack", {31'b0, Sl_xferAck}, 32'h1);
    OPB_Rst = 1'b1;
    @(negedge OPB_Clk);
    check("rst_kills_ack", {31'b0, Sl_xferAck}, 32'h0);
    OPB_select = 1'b0;
    @(negedge OPB_Clk);
    OPB_Rst = 1'b0;
    repeat (2) @(negedge OPB_Clk);
    #1 check("rst_ack_count", ack_count - start, 32'h1);
    rd(32'h0, 32'h0000_0000);
    rd(32'h4, 32'h0000_0000);

    // Counter wrap: 65535 captures reach 0xFFFF, one more wraps to zero.
    @(negedge OPB_Clk);
    for (int i = 0; i < 65535; i++) begin
      user_valid   = 1'b1;
      user_data_in = i;
      @(negedge OPB_Clk);
    end
    user_valid = 1'b0;
    rd(32'h4, 32'hFFFF_0003);
    pulse(32'hCAFE_F00D);
    rd(32'h4, 32'h0000_0003);
    rd(32'h0, 32'hCAFE_F00D);
    rd(32'h4, 32'h0000_0002);

    repeat (2) @(negedge OPB_Clk);
    check("scoreboard_drained", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
